bht_write_scheduler: RTL and testbench

- Owns the single write port of the 64-entry branch history table.
- Arbitrates among three sources: ID-stage allocation writes, EXE-stage saturating-counter updates, and a full-table invalidate walk used on context switch.
- EXE updates that collide with an allocation are buffered in a small queue rather than lost; when the queue is full they are dropped and counted.
- Sits between the predictor's lookup/decision logic and the table storage.

---
 rtl/bht_pkg.sv | 43 ++++
 rtl/bht_upd_queue.sv | 134 +++++++++++++
 rtl/bht_write_scheduler.sv | 172 +++++++++++++++++
 tb/tb_bht_write_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// ============================================================================
// Module   : bht_pkg
// Brief    : Shared constants, entry layout and FSM encoding for the BHT writer
// Revision : 1.0
// ============================================================================
`default_nettype none

package bht_pkg;

  localparam int BHT_ENTRIES = 64;
  localparam int BHT_ADDR_W  = 6;
  localparam int BHT_DATA_W  = 22;

  localparam int VALID_BIT = 21;
  localparam int TAG_MSB   = 20;
  localparam int TAG_LSB   = 13;
  localparam int TGT_MSB   = 12;
  localparam int TGT_LSB   = 2;
  localparam int CTR_MSB   = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } bht_state_e;

  function automatic logic [BHT_DATA_W-1:0] bht_make_entry(
    input logic                       valid,
    input logic [TAG_MSB-TAG_LSB:0]   tag,
    input logic [TGT_MSB-TGT_LSB:0]   tgt,
    input logic [CTR_MSB:0]           ctr
  );
    logic [BHT_DATA_W-1:0] e;
    e                    = '0;
    e[VALID_BIT]         = valid;
    e[TAG_MSB:TAG_LSB]   = tag;
    e[TGT_MSB:TGT_LSB]   = tgt;
    e[CTR_MSB:0]         = ctr;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bht_upd_queue.sv
// ============================================================================
// Module   : bht_upd_queue
// Brief    : Deferred-update FIFO with per-slot valid bits, address-match
//            invalidate and a head that skips invalidated slots combinationally
// Revision : 1.0
// ============================================================================
`default_nettype none

module bht_upd_queue
  import bht_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int ADDR_W = BHT_ADDR_W,
  parameter int DATA_W = BHT_DATA_W,
  parameter int PTR_W  = $clog2(QDEPTH),
  parameter int CW     = $clog2(QDEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              en,
  input  logic              flush,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic              deq,
  input  logic              enq,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic [CW-1:0]     count
);

  logic [QDEPTH-1:0] slot_vld;
  logic [ADDR_W-1:0] slot_addr [QDEPTH];
  logic [DATA_W-1:0] slot_data [QDEPTH];
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CW-1:0]     phys;

  logic [QDEPTH-1:0] eff_vld;
  logic [PTR_W-1:0]  head_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [CW-1:0]     skip;
  logic [CW-1:0]     remaining;
  logic              do_deq;
  logic              do_enq;

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      eff_vld[i] = slot_vld[i] & ~(inv_en && (slot_addr[i] == inv_addr));
    end
  end

  // Leading invalid slots are retired in the same cycle they are skipped.
  always_comb begin
    skip       = '0;
    head_valid = 1'b0;
    head_idx   = head_ptr;
    scan_idx   = head_ptr;
    for (int k = 0; k < QDEPTH; k++) begin
      scan_idx = head_ptr + PTR_W'(k);
      if (!head_valid && (CW'(k) < phys)) begin
        if (eff_vld[scan_idx]) begin
          head_valid = 1'b1;
          head_idx   = scan_idx;
        end else begin
          skip = skip + CW'(1);
        end
      end
    end
  end

  assign head_addr = slot_addr[head_idx];
  assign head_data = slot_data[head_idx];
  assign do_deq    = deq & head_valid;
  assign remaining = phys - skip - CW'(do_deq);
  assign full      = (remaining == CW'(QDEPTH));
  assign do_enq    = enq & ~full;

  always_comb begin
    count = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      count = count + CW'(slot_vld[i]);
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      slot_vld <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      phys     <= '0;
    end else if (en) begin
      if (flush) begin
        slot_vld <= '0;
        head_ptr <= '0;
        tail_ptr <= '0;
        phys     <= '0;
      end else begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (do_enq && (PTR_W'(i) == tail_ptr)) begin
            slot_vld[i] <= 1'b1;
          end else if (do_deq && (PTR_W'(i) == head_idx)) begin
            slot_vld[i] <= 1'b0;
          end else begin
            slot_vld[i] <= eff_vld[i];
          end
        end
        head_ptr <= head_ptr + PTR_W'(skip) + PTR_W'(do_deq);
        tail_ptr <= tail_ptr + PTR_W'(do_enq);
        phys     <= remaining + CW'(do_enq);
      end
    end
  end

  generate
    for (genvar g = 0; g < QDEPTH; g++) begin : g_slot
      always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
          slot_addr[g] <= '0;
          slot_data[g] <= '0;
        end else if (en && !flush && do_enq && (tail_ptr == PTR_W'(g))) begin
          slot_addr[g] <= enq_addr;
          slot_data[g] <= enq_data;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/bht_write_scheduler.sv
// ============================================================================
// Module   : bht_write_scheduler
// Brief    : Single BHT write port arbiter: allocation, deferred/live counter
//            updates and a full-table invalidate walk
// Revision : 1.0
// ============================================================================
`default_nettype none

module bht_write_scheduler
  import bht_pkg::*;
#(
  parameter int ENTRIES = BHT_ENTRIES,
  parameter int ADDR_W  = BHT_ADDR_W,
  parameter int DATA_W  = BHT_DATA_W,
  parameter int QDEPTH  = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      CLK,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      inv_req,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_addr,
  input  logic [DATA_W-1:0]         alloc_data,
  input  logic                      upd_valid,
  input  logic [ADDR_W-1:0]         upd_addr,
  input  logic [DATA_W-1:0]         upd_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      inv_busy,
  output logic                      inv_done,
  output logic                      upd_dropped,
  output logic [CNT_W-1:0]          drop_count,
  output logic [$clog2(QDEPTH):0]   q_count
);

  bht_state_e        state, state_n;
  logic [ADDR_W-1:0] walk_ptr, walk_ptr_n;

  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              walk_last;
  logic              drop;

  logic              q_flush;
  logic              q_inv_en;
  logic              q_deq;
  logic              q_enq;
  logic              q_head_valid;
  logic [ADDR_W-1:0] q_head_addr;
  logic [DATA_W-1:0] q_head_data;
  logic              q_full;

  bht_upd_queue #(
    .QDEPTH (QDEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .CLK        (CLK),
    .nrst       (nrst),
    .en         (en),
    .flush      (q_flush),
    .inv_en     (q_inv_en),
    .inv_addr   (alloc_addr),
    .deq        (q_deq),
    .enq        (q_enq),
    .enq_addr   (upd_addr),
    .enq_data   (upd_data),
    .head_valid (q_head_valid),
    .head_addr  (q_head_addr),
    .head_data  (q_head_data),
    .full       (q_full),
    .count      (q_count)
  );

  always_comb begin
    state_n    = state;
    walk_ptr_n = walk_ptr;
    sel_valid  = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    walk_last  = 1'b0;
    q_flush    = 1'b0;
    q_inv_en   = 1'b0;
    q_deq      = 1'b0;
    q_enq      = 1'b0;
    case (state)
      IDLE: begin
        if (inv_req) begin
          state_n    = WALK;
          walk_ptr_n = '0;
          q_flush    = 1'b1;
        end else if (alloc_valid) begin
          sel_valid = 1'b1;
          sel_addr  = alloc_addr;
          sel_data  = alloc_data;
          q_inv_en  = 1'b1;
          // An update to the slot being reallocated is stale; discard silently.
          q_enq     = upd_valid && (upd_addr != alloc_addr);
        end else if (q_head_valid) begin
          sel_valid = 1'b1;
          sel_addr  = q_head_addr;
          sel_data  = q_head_data;
          q_deq     = 1'b1;
          q_enq     = upd_valid;
        end else if (upd_valid) begin
          sel_valid = 1'b1;
          sel_addr  = upd_addr;
          sel_data  = upd_data;
        end
      end
      WALK: begin
        sel_valid = 1'b1;
        sel_addr  = walk_ptr;
        sel_data  = DATA_W'(bht_make_entry(1'b0, '0, '0, '0));
        if (walk_ptr == ADDR_W'(ENTRIES - 1)) begin
          state_n   = IDLE;
          walk_last = 1'b1;
        end else begin
          walk_ptr_n = walk_ptr + ADDR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign drop = q_enq & q_full;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      walk_ptr <= '0;
    end else if (en) begin
      state    <= state_n;
      walk_ptr <= walk_ptr_n;
    end
  end

  // Busy stays up through the cycle the final walk write is presented.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      inv_busy    <= 1'b0;
      inv_done    <= 1'b0;
      upd_dropped <= 1'b0;
      drop_count  <= '0;
    end else if (en) begin
      wr_en       <= sel_valid;
      if (sel_valid) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      inv_busy    <= (state == WALK) || (state_n == WALK);
      inv_done    <= walk_last;
      upd_dropped <= drop;
      if (drop && (drop_count != {CNT_W{1'b1}})) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end else begin
      wr_en       <= 1'b0;
      inv_done    <= 1'b0;
      upd_dropped <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bht_write_scheduler.sv
// ============================================================================
// Module   : tb_bht_write_scheduler
// Brief    : Directed vector table plus hand sequences for walk, enable and reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bht_write_scheduler;

  logic        CLK;
  logic        nrst;
  logic        en;
  logic        inv_req;
  logic        alloc_valid;
  logic [5:0]  alloc_addr;
  logic [21:0] alloc_data;
  logic        upd_valid;
  logic [5:0]  upd_addr;
  logic [21:0] upd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [21:0] wr_data;
  logic        inv_busy;
  logic        inv_done;
  logic        upd_dropped;
  logic [7:0]  drop_count;
  logic [1:0]  q_count;

  int tests;
  int failed;

  bht_write_scheduler dut (
    .CLK         (CLK),
    .nrst        (nrst),
    .en          (en),
    .inv_req     (inv_req),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_data  (alloc_data),
    .upd_valid   (upd_valid),
    .upd_addr    (upd_addr),
    .upd_data    (upd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .inv_busy    (inv_busy),
    .inv_done    (inv_done),
    .upd_dropped (upd_dropped),
    .drop_count  (drop_count),
    .q_count     (q_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        av;
    logic [5:0]  aa;
    logic [21:0] ad;
    logic        uv;
    logic [5:0]  ua;
    logic [21:0] ud;
    logic        ew;
    logic [5:0]  ea;
    logic [21:0] ed;
    logic [1:0]  eq;
    logic        edrop;
    logic [7:0]  edc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    inv_req     = 1'b0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    alloc_data  = '0;
    upd_valid   = 1'b0;
    upd_addr    = '0;
    upd_data    = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests  = 0;
    failed = 0;

    //          av    aa     ad         uv    ua     ud         ew    ea     ed         eq  drop  dc
    vecs[0]  = '{1'b0, 6'h00, 22'h000000, 1'b1, 6'h05, 22'h200003, 1'b1, 6'h05, 22'h200003, 2'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 6'h10, 22'h3ABCD1, 1'b1, 6'h22, 22'h100002, 1'b1, 6'h10, 22'h3ABCD1, 2'd1, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b1, 6'h22, 22'h100002, 2'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 6'h30, 22'h2C0001, 1'b1, 6'h01, 22'h000101, 1'b1, 6'h30, 22'h2C0001, 2'd1, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 6'h31, 22'h2C0002, 1'b1, 6'h02, 22'h000202, 1'b1, 6'h31, 22'h2C0002, 2'd2, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 6'h32, 22'h2C0003, 1'b1, 6'h03, 22'h000303, 1'b1, 6'h32, 22'h2C0003, 2'd2, 1'b1, 8'd1};
    vecs[6]  = '{1'b1, 6'h33, 22'h2C0004, 1'b0, 6'h00, 22'h000000, 1'b1, 6'h33, 22'h2C0004, 2'd2, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b1, 6'h01, 22'h000101, 2'd1, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b1, 6'h02, 22'h000202, 2'd0, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 2'd0, 1'b0, 8'd1};
    vecs[10] = '{1'b1, 6'h11, 22'h255555, 1'b1, 6'h08, 22'h0AAAAA, 1'b1, 6'h11, 22'h255555, 2'd1, 1'b0, 8'd1};
    vecs[11] = '{1'b1, 6'h08, 22'h3FFFFE, 1'b0, 6'h00, 22'h000000, 1'b1, 6'h08, 22'h3FFFFE, 2'd0, 1'b0, 8'd1};
    vecs[12] = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 2'd0, 1'b0, 8'd1};
    vecs[13] = '{1'b1, 6'h15, 22'h211111, 1'b1, 6'h15, 22'h122222, 1'b1, 6'h15, 22'h211111, 2'd0, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 2'd0, 1'b0, 8'd1};
    vecs[15] = '{1'b1, 6'h20, 22'h200020, 1'b1, 6'h21, 22'h000021, 1'b1, 6'h20, 22'h200020, 2'd1, 1'b0, 8'd1};
    vecs[16] = '{1'b0, 6'h00, 22'h000000, 1'b1, 6'h22, 22'h000022, 1'b1, 6'h21, 22'h000021, 2'd1, 1'b0, 8'd1};
    vecs[17] = '{1'b0, 6'h00, 22'h000000, 1'b0, 6'h00, 22'h000000, 1'b1, 6'h22, 22'h000022, 2'd0, 1'b0, 8'd1};

    nrst = 1'b0;
    en   = 1'b1;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset wr_en",       32'(wr_en),       32'h0);
    chk("reset wr_addr",     32'(wr_addr),     32'h0);
    chk("reset wr_data",     32'(wr_data),     32'h0);
    chk("reset inv_busy",    32'(inv_busy),    32'h0);
    chk("reset inv_done",    32'(inv_done),    32'h0);
    chk("reset upd_dropped", 32'(upd_dropped), 32'h0);
    chk("reset drop_count",  32'(drop_count),  32'h0);
    chk("reset q_count",     32'(q_count),     32'h0);
    @(negedge CLK);
    nrst = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      alloc_valid = vecs[i].av;
      alloc_addr  = vecs[i].aa;
      alloc_data  = vecs[i].ad;
      upd_valid   = vecs[i].uv;
      upd_addr    = vecs[i].ua;
      upd_data    = vecs[i].ud;
      step();
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].ew));
      if (vecs[i].ew) begin
        chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].ea));
        chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vecs[i].ed));
      end
      chk($sformatf("v%0d q_count", i),     32'(q_count),     32'(vecs[i].eq));
      chk($sformatf("v%0d upd_dropped", i), 32'(upd_dropped), 32'(vecs[i].edrop));
      chk($sformatf("v%0d drop_count", i),  32'(drop_count),  32'(vecs[i].edc));
    end
    idle_inputs();

    // Drop counter saturation: two updates queue, the rest drop.
    alloc_valid = 1'b1;
    alloc_addr  = 6'h3F;
    alloc_data  = 22'h000001;
    upd_valid   = 1'b1;
    upd_addr    = 6'h0A;
    upd_data    = 22'h000005;
    for (int i = 0; i < 300; i++) step();
    chk("sat drop_count",  32'(drop_count),  32'hFF);
    chk("sat upd_dropped", 32'(upd_dropped), 32'h1);
    chk("sat q_count",     32'(q_count),     32'h2);
    idle_inputs();
    step();
    chk("drain0 wr_en",   32'(wr_en),   32'h1);
    chk("drain0 wr_addr", 32'(wr_addr), 32'h0A);
    chk("drain0 q_count", 32'(q_count), 32'h1);
    step();
    chk("drain1 wr_en",   32'(wr_en),   32'h1);
    chk("drain1 q_count", 32'(q_count), 32'h0);
    step();
    chk("drain2 wr_en",   32'(wr_en),   32'h0);

    // Full invalidate walk with competing requests held throughout.
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    chk("walk start inv_busy", 32'(inv_busy), 32'h1);
    chk("walk start wr_en",    32'(wr_en),    32'h0);
    alloc_valid = 1'b1;
    alloc_addr  = 6'h05;
    alloc_data  = 22'h3F0F0F;
    upd_valid   = 1'b1;
    upd_addr    = 6'h06;
    upd_data    = 22'h012345;
    for (int k = 0; k < 64; k++) begin
      step();
      chk($sformatf("walk%0d wr_en", k),    32'(wr_en),    32'h1);
      chk($sformatf("walk%0d wr_addr", k),  32'(wr_addr),  32'(k));
      chk($sformatf("walk%0d wr_data", k),  32'(wr_data),  32'h0);
      chk($sformatf("walk%0d inv_busy", k), 32'(inv_busy), 32'h1);
      chk($sformatf("walk%0d inv_done", k), 32'(inv_done), (k == 63) ? 32'h1 : 32'h0);
    end
    idle_inputs();
    step();
    chk("post walk wr_en",      32'(wr_en),      32'h0);
    chk("post walk inv_busy",   32'(inv_busy),   32'h0);
    chk("post walk inv_done",   32'(inv_done),   32'h0);
    chk("post walk q_count",    32'(q_count),    32'h0);
    chk("post walk drop_count", 32'(drop_count), 32'hFF);

    // Second walk: pause with en=0, then reset at address 20.
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("w2 %0d wr_addr", k), 32'(wr_addr), 32'(k));
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("pause%0d wr_en", k),    32'(wr_en),    32'h0);
      chk($sformatf("pause%0d inv_busy", k), 32'(inv_busy), 32'h1);
    end
    en = 1'b1;
    for (int k = 10; k <= 20; k++) begin
      step();
      chk($sformatf("w2 %0d wr_en", k),   32'(wr_en),   32'h1);
      chk($sformatf("w2 %0d wr_addr", k), 32'(wr_addr), 32'(k));
    end
    nrst = 1'b0;
    #1;
    chk("async rst wr_en",      32'(wr_en),      32'h0);
    chk("async rst wr_addr",    32'(wr_addr),    32'h0);
    chk("async rst inv_busy",   32'(inv_busy),   32'h0);
    chk("async rst drop_count", 32'(drop_count), 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("after rst%0d wr_en", k),    32'(wr_en),    32'h0);
      chk($sformatf("after rst%0d inv_done", k), 32'(inv_done), 32'h0);
      chk($sformatf("after rst%0d inv_busy", k), 32'(inv_busy), 32'h0);
    end
    alloc_valid = 1'b1;
    alloc_addr  = 6'h2A;
    alloc_data  = 22'h2AAAAA;
    step();
    chk("post rst alloc wr_en",   32'(wr_en),   32'h1);
    chk("post rst alloc wr_addr", 32'(wr_addr), 32'h2A);
    chk("post rst alloc wr_data", 32'(wr_data), 32'h2AAAAA);
    idle_inputs();
    step();
    chk("final wr_en", 32'(wr_en), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
